// File: rtl/axis_row_framer_pkg.sv
// Shared definitions for the row framer: FSM encoding, row defaults, pad word, log2 helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package axis_row_framer_pkg;

    typedef enum logic [1:0] {
        PASS = 2'd0,
        PAD  = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam int ROW_WIDTH_DEFAULT = 36;
    localparam int PAD_VALUE         = 0;

    // Number of bits needed to index 'value' distinct entries (ceil(log2(value))).
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer with registered valid on the output and registered ready on the input.
// Latency: 1 cycle from input handshake to out_vld; 1 word/cycle sustained.
// Backpressure: in_rdy drops only once both entries hold data; full_nxt lets the caller pre-register its own ready.
module axis_skid_buffer #(
    parameter int PAYLOAD_W = 33
) (
    input  logic                 s00_axis_aclk,
    input  logic                 s00_axis_aresetn,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [PAYLOAD_W-1:0] in_dat,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [PAYLOAD_W-1:0] out_dat,
    output logic                 full_nxt
);

    logic                 main_vld;
    logic                 skid_vld;
    logic                 main_vld_nxt;
    logic                 skid_vld_nxt;
    logic                 push;
    logic                 pop;
    logic [PAYLOAD_W-1:0] main_dat;
    logic [PAYLOAD_W-1:0] skid_dat;

    // The skid entry only fills when the output entry is held, so it alone signals full.
    assign in_rdy   = !skid_vld;
    assign push     = in_vld && in_rdy;
    assign pop      = main_vld && out_rdy;
    assign out_vld  = main_vld;
    assign out_dat  = main_dat;
    assign full_nxt = skid_vld_nxt;

    // Occupancy of both entries for the next cycle.
    always_comb begin
        main_vld_nxt = skid_vld || push || (main_vld && !pop);
        skid_vld_nxt = skid_vld ? !pop : (push && main_vld && !pop);
    end

    // Valid flags.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else begin
            main_vld <= main_vld_nxt;
            skid_vld <= skid_vld_nxt;
        end
    end

    // Payload movement: skid refills the output first, a new word lands wherever there is room.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            main_dat <= '0;
            skid_dat <= '0;
        end else begin
            if (pop && skid_vld) begin
                main_dat <= skid_dat;
            end else if (push && (!main_vld || pop)) begin
                main_dat <= in_dat;
            end
            if (push && main_vld && !pop) begin
                skid_dat <= in_dat;
            end
        end
    end

endmodule

// File: rtl/axis_row_framer.sv
// Re-frames an arbitrary-length stream into whole rows, zero-padding the last row and truncating at row_limit.
// Latency: 1 cycle from input accept to m00_axis_tvalid; 1 word/cycle sustained.
// Backpressure: registered s00_axis_tready follows skid occupancy; held low while padding, forced high while dropping.
module axis_row_framer
    import axis_row_framer_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int ROW_WIDTH_IN_WORD  = ROW_WIDTH_DEFAULT,
    parameter int ROW_CNT_WIDTH      = 12
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_aresetn,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    input  logic                              s00_axis_tlast,
    input  logic                              s00_axis_tvalid,
    output logic                              s00_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                              m00_axis_tlast,
    output logic                              m00_axis_tvalid,
    input  logic                              m00_axis_tready,
    input  logic [ROW_CNT_WIDTH-1:0]          row_limit,
    output logic [ROW_CNT_WIDTH-1:0]          rows_in_frame,
    output logic                              frame_done,
    output logic                              frame_err
);

    localparam int STRB_W = C_AXIS_TDATA_WIDTH / 8;
    localparam int PTR_W  = (clogb2(ROW_WIDTH_IN_WORD) > 0) ? clogb2(ROW_WIDTH_IN_WORD) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ROW_WIDTH_IN_WORD - 1);

    typedef struct packed {
        logic                          last;
        logic [C_AXIS_TDATA_WIDTH-1:0] data;
    } beat_t;

    state_t                         state_q;
    state_t                         state_nxt;
    logic [PTR_W-1:0]               word_ptr;
    logic [ROW_CNT_WIDTH-1:0]       limit_q;
    logic [ROW_CNT_WIDTH-1:0]       rows_cur;
    logic [ROW_CNT_WIDTH-1:0]       limit_cur;
    logic [C_AXIS_TDATA_WIDTH-1:0]  masked_dat;
    logic                           frame_start;
    logic                           in_acc;
    logic                           row_end;
    logic                           limit_hit;
    logic                           push_vld;
    logic                           skid_rdy;
    logic                           skid_full_nxt;
    beat_t                          push_dat;
    beat_t                          pop_dat;

    // At the first word of a frame the previous frame's count and limit no longer apply.
    assign in_acc    = s00_axis_tvalid && s00_axis_tready;
    assign row_end   = (word_ptr == LAST_PTR);
    assign rows_cur  = frame_start ? '0 : rows_in_frame;
    assign limit_cur = frame_start ? row_limit : limit_q;
    assign limit_hit = row_end && (limit_cur != '0) && ((rows_cur + ROW_CNT_WIDTH'(1)) == limit_cur);

    // Byte strobe masking: a deasserted strobe zeroes its byte.
    always_comb begin
        masked_dat = '0;
        for (int i = 0; i < STRB_W; i++) begin
            masked_dat[8*i +: 8] = s00_axis_tstrb[i] ? s00_axis_tdata[8*i +: 8] : 8'h00;
        end
    end

    // FSM state register.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q <= PASS;
        end else begin
            state_q <= state_nxt;
        end
    end

    // FSM next state: short frames pad out, over-long frames drop their tail.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            PASS: begin
                if (in_acc) begin
                    if (s00_axis_tlast) begin
                        state_nxt = row_end ? PASS : PAD;
                    end else if (limit_hit) begin
                        state_nxt = DROP;
                    end
                end
            end
            PAD: begin
                if (push_vld && row_end) begin
                    state_nxt = PASS;
                end
            end
            DROP: begin
                if (in_acc && s00_axis_tlast) begin
                    state_nxt = PASS;
                end
            end
            default: state_nxt = PASS;
        endcase
    end

    // FSM outputs: what goes into the skid this cycle. Input tlast takes priority over the limit.
    always_comb begin
        push_vld = 1'b0;
        push_dat = '0;
        case (state_q)
            PASS: begin
                push_vld      = in_acc;
                push_dat.data = masked_dat;
                push_dat.last = s00_axis_tlast ? row_end : limit_hit;
            end
            PAD: begin
                push_vld      = skid_rdy;
                push_dat.data = C_AXIS_TDATA_WIDTH'(PAD_VALUE);
                push_dat.last = row_end;
            end
            default: begin
                push_vld = 1'b0;
            end
        endcase
    end

    // Row bookkeeping on every pushed word, plus the sticky truncation flag.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            word_ptr      <= '0;
            rows_in_frame <= '0;
            limit_q       <= '0;
            frame_start   <= 1'b1;
            frame_err     <= 1'b0;
        end else begin
            if (push_vld) begin
                word_ptr      <= row_end ? '0 : word_ptr + PTR_W'(1);
                rows_in_frame <= rows_cur + ROW_CNT_WIDTH'(row_end);
                frame_start   <= push_dat.last;
                if (frame_start) begin
                    limit_q <= row_limit;
                end
            end
            if ((state_q == PASS) && in_acc && frame_start) begin
                frame_err <= 1'b0;
            end
            if ((state_q == PASS) && in_acc && limit_hit && !s00_axis_tlast) begin
                frame_err <= 1'b1;
            end
        end
    end

    // Ready is registered from next-cycle state and skid occupancy, so an accepted word always has room.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            s00_axis_tready <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            s00_axis_tready <= (state_nxt == DROP) || ((state_nxt == PASS) && !skid_full_nxt);
            frame_done      <= m00_axis_tvalid && m00_axis_tready && m00_axis_tlast;
        end
    end

    axis_skid_buffer #(
        .PAYLOAD_W ($bits(beat_t))
    ) u_skid (
        .s00_axis_aclk    (s00_axis_aclk),
        .s00_axis_aresetn (s00_axis_aresetn),
        .in_vld           (push_vld),
        .in_rdy           (skid_rdy),
        .in_dat           (push_dat),
        .out_vld          (m00_axis_tvalid),
        .out_rdy          (m00_axis_tready),
        .out_dat          (pop_dat),
        .full_nxt         (skid_full_nxt)
    );

    assign m00_axis_tdata = pop_dat.data;
    assign m00_axis_tlast = pop_dat.last;
    assign m00_axis_tstrb = '1;

endmodule

// File: tb/tb_axis_row_framer.sv
// Scoreboard bench for axis_row_framer: directed frames, expected words queued at issue time.
// Latency: n/a (testbench).
// Backpressure: m00 ready either held high or cycled 1,0,0,1; input valid optionally gapped.
module tb_axis_row_framer;

    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int RCW = 12;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [DW-1:0]  s_tdata = '0;
    logic [SW-1:0]  s_tstrb = '0;
    logic           s_tlast = 1'b0;
    logic           s_tvalid = 1'b0;
    logic           s_tready;
    logic [DW-1:0]  m_tdata;
    logic [SW-1:0]  m_tstrb;
    logic           m_tlast;
    logic           m_tvalid;
    logic           m_tready = 1'b1;
    logic [RCW-1:0] row_limit = '0;
    logic [RCW-1:0] rows_in_frame;
    logic           frame_done;
    logic           frame_err;

    typedef struct packed {
        logic [31:0] dat;
        logic        last;
    } exp_t;

    exp_t     exp_q[$];
    int       n_tests = 0;
    int       n_fail = 0;
    bit       exp_done = 1'b0;
    bit       rdy_toggle = 1'b0;
    bit [3:0] rdy_pat = 4'b1001;
    int       rdy_cyc = 0;
    bit       cnt_en = 1'b0;
    int       low_cyc = 0;

    always #5 clk = ~clk;

    axis_row_framer #(
        .C_AXIS_TDATA_WIDTH (DW),
        .ROW_WIDTH_IN_WORD  (36),
        .ROW_CNT_WIDTH      (RCW)
    ) dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis_tdata   (s_tdata),
        .s00_axis_tstrb   (s_tstrb),
        .s00_axis_tlast   (s_tlast),
        .s00_axis_tvalid  (s_tvalid),
        .s00_axis_tready  (s_tready),
        .m00_axis_tdata   (m_tdata),
        .m00_axis_tstrb   (m_tstrb),
        .m00_axis_tlast   (m_tlast),
        .m00_axis_tvalid  (m_tvalid),
        .m00_axis_tready  (m_tready),
        .row_limit        (row_limit),
        .rows_in_frame    (rows_in_frame),
        .frame_done       (frame_done),
        .frame_err        (frame_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_s_tready"}, s_tready, 0);
        check({tag, "_m_tvalid"}, m_tvalid, 0);
        check({tag, "_m_tdata"}, m_tdata, 0);
        check({tag, "_m_tlast"}, m_tlast, 0);
        check({tag, "_rows"}, rows_in_frame, 0);
        check({tag, "_done"}, frame_done, 0);
        check({tag, "_err"}, frame_err, 0);
    endtask

    // Queue the hand-computed output of one frame: n_data input words then zeros, tlast on the final word.
    task automatic expect_frame(input int n_out, input int n_data, input logic [31:0] base, input int odd_idx);
        exp_t e;
        for (int i = 0; i < n_out; i++) begin
            e.dat  = (i < n_data) ? base + i : 32'h0;
            if (i == odd_idx) e.dat = 32'h0000BEEF;
            e.last = (i == n_out - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_word(input logic [31:0] d, input logic [3:0] s, input logic l, input bit rv);
        int  g;
        bit  hs;
        if (rv) begin
            repeat ($urandom_range(0, 2)) begin
                s_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        s_tdata  = d;
        s_tstrb  = s;
        s_tlast  = l;
        s_tvalid = 1'b1;
        g  = 0;
        hs = 1'b0;
        while (!hs && g < 2000) begin
            @(negedge clk);
            hs = s_tready;
            @(posedge clk);
            #1;
            g++;
        end
        if (!hs) begin
            n_tests++;
            n_fail++;
            $display("FAIL handshake_timeout: got no s00 ready for 0x%0h, expected ready within 2000 cycles", d);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Words lo..hi of an n-word frame; word odd_idx carries 0xDEADBEEF with strobe 0011.
    task automatic send_range(input int lo, input int hi, input int n, input logic [31:0] base,
                              input int odd_idx, input bit rv);
        logic [31:0] d;
        logic [3:0]  s;
        for (int i = lo; i <= hi; i++) begin
            d = base + i;
            s = 4'hF;
            if (i == odd_idx) begin
                d = 32'hDEADBEEF;
                s = 4'b0011;
            end
            drive_word(d, s, i == n - 1, rv);
        end
    endtask

    task automatic wait_drain(input string name);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 5000) begin
            @(posedge clk);
            g++;
        end
        check({name, "_drain_left"}, exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Downstream ready pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_toggle) begin
                m_tready = rdy_pat[rdy_cyc % 4];
                rdy_cyc++;
            end else begin
                m_tready = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every output handshake and checks the frame_done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_done = 1'b0;
            end else begin
                if (exp_done || frame_done) begin
                    check("frame_done", frame_done, exp_done);
                end
                exp_done = 1'b0;
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_output: got 0x%0h, expected no word", m_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", m_tdata, e.dat);
                        check("out_last", m_tlast, e.last);
                        check("out_strb", m_tstrb, 4'hF);
                        if (e.last) exp_done = 1'b1;
                    end
                end
                if (cnt_en && !s_tready) low_cyc++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before 1000000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("tready_rise", s_tready, 1);

        // One exact row.
        expect_frame(36, 36, 32'h0, -1);
        send_range(0, 35, 36, 32'h0, -1, 1'b0);
        wait_drain("s1");
        check("s1_rows", rows_in_frame, 1);
        check("s1_err", frame_err, 0);

        // Short second row padded with 32 zeros.
        low_cyc = 0;
        cnt_en  = 1'b1;
        expect_frame(72, 40, 32'h0, -1);
        send_range(0, 39, 40, 32'h0, -1, 1'b0);
        wait_drain("s2");
        cnt_en = 1'b0;
        check("s2_pad_tready_low", low_cyc, 32);
        check("s2_rows", rows_in_frame, 2);

        // Stalling downstream with gapped input.
        rdy_toggle = 1'b1;
        expect_frame(36, 36, 32'h0, -1);
        send_range(0, 35, 36, 32'h0, -1, 1'b1);
        wait_drain("s3");
        rdy_toggle = 1'b0;
        check("s3_rows", rows_in_frame, 1);

        // Strobe masking.
        expect_frame(36, 36, 32'h1000, 5);
        send_range(0, 35, 36, 32'h1000, 5, 1'b0);
        wait_drain("s4");

        // Row limit truncation, tail absorbed with ready held high.
        row_limit = 12'd1;
        low_cyc   = 0;
        cnt_en    = 1'b1;
        expect_frame(36, 36, 32'h2000, -1);
        send_range(0, 49, 50, 32'h2000, -1, 1'b0);
        wait_drain("s5");
        cnt_en = 1'b0;
        check("s5_drop_tready_low", low_cyc, 0);
        check("s5_err_set", frame_err, 1);
        check("s5_rows", rows_in_frame, 1);
        row_limit = '0;
        expect_frame(36, 36, 32'h3000, -1);
        send_range(0, 0, 36, 32'h3000, -1, 1'b0);
        check("s5_err_clear", frame_err, 0);
        send_range(1, 35, 36, 32'h3000, -1, 1'b0);
        wait_drain("s5b");
        check("s5b_rows", rows_in_frame, 1);

        // Reset in the middle of a frame.
        expect_frame(36, 36, 32'h4000, -1);
        send_range(0, 9, 36, 32'h4000, -1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_frame(36, 36, 32'h5000, -1);
        send_range(0, 35, 36, 32'h5000, -1, 1'b0);
        wait_drain("s6");
        check("s6_rows", rows_in_frame, 1);
        check("s6_err", frame_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_row_framer.md
Name: axis_row_framer

Overview:
- Upstream stage feeding the AXI-Stream-to-BRAM adapter's slave stream port.
- Takes an arbitrary-length DMA stream and re-frames it into whole BRAM rows of ROW_WIDTH_IN_WORD words; a short final row is zero-padded.
- Asserts tlast only on the final word of the last row, enforces a row limit, and reports frame status to software.

Parameters:
- C_AXIS_TDATA_WIDTH, 32, data width of both streams (bits).
- ROW_WIDTH_IN_WORD, 36, words per BRAM row (1152 bits at 32-bit words).
- ROW_CNT_WIDTH, 12, width of the row counter and row limit (matches BRAM depth).

Ports:
- s00_axis_aclk  in  1  single clock for the whole block.
- s00_axis_aresetn  in  1  reset, asynchronous, active-low.
- s00_axis_tdata  in  C_AXIS_TDATA_WIDTH  input word.
- s00_axis_tstrb  in  C_AXIS_TDATA_WIDTH/8  byte strobes; a 0 strobe zeroes its byte.
- s00_axis_tlast  in  1  end of input frame.
- s00_axis_tvalid  in  1  input valid.
- s00_axis_tready  out  1  input ready (registered).
- m00_axis_tdata  out  C_AXIS_TDATA_WIDTH  output word (registered).
- m00_axis_tstrb  out  C_AXIS_TDATA_WIDTH/8  always all ones.
- m00_axis_tlast  out  1  final word of the final row.
- m00_axis_tvalid  out  1  output valid (registered).
- m00_axis_tready  in  1  downstream ready.
- row_limit  in  ROW_CNT_WIDTH  maximum rows per frame; sampled at frame start; 0 means no limit.
- rows_in_frame  out  ROW_CNT_WIDTH  rows completed in the current or last frame.
- frame_done  out  1  one-cycle pulse after the handshake of the word carrying m00_axis_tlast.
- frame_err  out  1  sticky: frame truncated at row_limit; cleared at the next frame's first accepted word.

Behaviour:
Reset values
- s00_axis_tready=0, m00_axis_tvalid=0, m00_axis_tdata=0, m00_axis_tlast=0.
- rows_in_frame=0, frame_done=0, frame_err=0, word_ptr=0, state=PASS.
- s00_axis_tready rises on the first clock after reset deassertion.

Datapath
- Internal two-entry skid buffer (sub-module) between the framer and the m00 port.
- s00_axis_tready = state==DROP, or (state==PASS and skid not full); registered.
- Fall-through latency: 1 cycle from input accept to m00_axis_tvalid.
- Sustained throughput: 1 word/cycle under constant m00_axis_tready.
- Words are never lost, duplicated or reordered under any tready/tvalid pattern.
- word_ptr (clogb2(ROW_WIDTH_IN_WORD) bits) counts words pushed into the skid, input and pad words alike; it wraps from ROW_WIDTH_IN_WORD-1 to 0.
- Each wrap increments rows_in_frame; the first push of a new frame loads rows_in_frame=0.

State PASS
- Accepted words are pushed into the skid with tstrb masking applied.
- Input tlast at word_ptr==ROW_WIDTH_IN_WORD-1: push with tlast=1; state stays PASS.
- Input tlast at word_ptr<ROW_WIDTH_IN_WORD-1: push with tlast=0, then go to PAD.
- Row completion with rows_in_frame+1==row_limit (row_limit!=0) and no input tlast on that word: push that word with tlast=1, set frame_err, go to DROP.
- Input tlast wins over the row-limit check when both occur on the same word (no error).

State PAD
- s00_axis_tready=0.
- Push zero words (one per cycle when the skid has space) until word_ptr==ROW_WIDTH_IN_WORD-1; that word carries tlast=1. Then return to PASS.

State DROP
- s00_axis_tready=1; accepted words are discarded.
- Return to PASS on the cycle after the input tlast is accepted.

Reset mid-operation
- All state, counters and the skid clear immediately.
- A partially emitted row is abandoned; downstream recovers via its own reset.

Decomposition:
- Package axis_row_framer_pkg holds:
  - the clogb2 function;
  - the state encoding PASS=2'd0, PAD=2'd1, DROP=2'd2;
  - the default row width 36 and the pad value 0.
- Sub-module axis_skid_buffer: two-entry, registered valid/ready, parameterised on payload width (data+tlast).

Test Plan:
- 36 words 0..35, tlast on word 35, m00_axis_tready=1 -> 36 outputs in order, tlast only on 35, rows_in_frame=1, frame_done one cycle after, frame_err=0.
- 40 words, tlast on word 39 -> 72 outputs: 0..39 then 32 zeros, tlast on output 71, s00_axis_tready=0 for the 32 pad cycles, rows_in_frame=2.
- 36-word frame with m00_axis_tready toggled 1,0,0,1 and s00_axis_tvalid random -> output sequence identical to the first scenario, no gap beyond 1 cycle after ready returns.
- Word 0xDEADBEEF with tstrb=4'b0011 in a 36-word frame -> output word 0x0000BEEF, m00_axis_tstrb=4'hF.
- row_limit=1, 50 words, tlast on 49 -> 36 outputs, tlast on 35, frame_err=1, words 36..49 absorbed with tready=1, next frame's first accepted word clears frame_err.
- Assert reset after 10 of 36 words accepted -> all outputs return to reset values within the reset cycle; a following 36-word frame emits exactly 36 words with rows_in_frame=1.
